// File: rtl/adv7393_frame_fetch_if.sv
// AXI read-address channel plus the monitored R-channel status between the frame fetcher and the memory port.
// Latency: none (plain wires).
// Backpressure: arvalid/arready handshake on AR; rvalid/rready are only observed by the fetcher.
interface adv7393_frame_fetch_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [1:0]  rresp;

    modport master (
        output araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
        input  arready, rvalid, rready, rlast, rresp
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
        output arready, rvalid, rready, rlast, rresp
    );
endinterface

// File: rtl/adv7393_frame_fetch.sv
// Frame fetch: issues 4 KB-safe INCR read bursts for every active line, gated by line-FIFO credit.
// Latency: first arvalid 2 cycles after frame_start; 1 CALC cycle between bursts; frame_done 1 cycle after last beat.
// Backpressure: AR held stable until arready; no burst issued unless fifo_free covers in-flight beats plus the new burst.
// Optional feature: define ADV7393_FETCH_ERR_ABORT_EN to stop issuing ARs once an error response is flagged.
module adv7393_frame_fetch #(
    parameter int  M_AXI_DWIDTH = 128,
    parameter int  MAX_BURST    = 16,
    parameter int  FIFO_WORDS   = 512,
    localparam int FW           = $clog2(FIFO_WORDS) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 frame_start,
    input  logic [31:0]          cfg_base_addr,
    input  logic [31:0]          cfg_stride,
    input  logic [11:0]          cfg_line_words,
    input  logic [10:0]          cfg_lines,
    input  logic [FW-1:0]        fifo_free,
    input  logic                 err_clr,
    adv7393_frame_fetch_if.master m_axi,
    output logic                 busy,
    output logic                 frame_done,
    output logic [10:0]          line_cnt,
    output logic                 err_resp,
    output logic                 err_overrun
);

    localparam int BPB      = M_AXI_DWIDTH / 8;
    localparam int BPB_LOG2 = $clog2(BPB);
    // Credit arithmetic must hold both the FIFO count and a 13-bit burst length without overflow.
    localparam int CW       = ((FW > 13) ? FW : 13) + 1;

    typedef enum logic [1:0] {IDLE, CALC, ADDR, DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_line_addr;
    logic [31:0]     r_addr;
    logic [31:0]     r_cfg_stride;
    logic [11:0]     r_cfg_line_words;
    logic [10:0]     r_cfg_lines;
    logic [11:0]     r_remaining;
    logic [11:0]     r_len;
    logic [10:0]     r_line_cnt;
    logic [FW-1:0]   r_outstanding;
    logic [FW-1:0]   w_out_nxt;

    logic [31:0]     r_araddr;
    logic [7:0]      r_arlen;
    logic            r_arvalid;

    logic            r_busy;
    logic            r_frame_done;
    logic            r_err_resp;
    logic            r_err_overrun;

    logic            w_start;
    logic            w_issue;
    logic            w_done;
    logic            w_hs;
    logic            w_beat;
    logic            w_abort;
    logic            w_credit;
    logic            w_line_end;
    logic            w_last_line;
    logic [12:0]     w_room;
    logic [12:0]     w_len;
    logic [11:0]     w_rem_after;
    logic [CW-1:0]   w_need;
    logic            w_unused;

    assign w_hs   = r_arvalid & m_axi.arready;
    assign w_beat = m_axi.rvalid & m_axi.rready;

    // Beats left before the next 4 KB page; addresses are beat-aligned so the shift is exact.
    assign w_room = 13'((14'd4096 - {2'b00, r_addr[11:0]}) >> BPB_LOG2);

    // Burst length is the smallest of line remainder, burst cap and distance to the page edge.
    always_comb begin
        w_len = w_room;
        if ({1'b0, r_remaining} < w_len) begin
            w_len = {1'b0, r_remaining};
        end
        if (13'(MAX_BURST) < w_len) begin
            w_len = 13'(MAX_BURST);
        end
    end

    assign w_need      = CW'(r_outstanding) + CW'(w_len);
    assign w_credit    = (CW'(fifo_free) >= w_need);
    assign w_rem_after = r_remaining - r_len;
    assign w_line_end  = (w_rem_after == 12'd0);
    assign w_last_line = ((r_line_cnt + 11'd1) == r_cfg_lines);

`ifdef ADV7393_FETCH_ERR_ABORT_EN
    assign w_abort = r_err_resp;
`else
    assign w_abort = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and single-cycle control strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && frame_start) begin
                    w_start = 1'b1;
                    if ((cfg_lines == 11'd0) || (cfg_line_words == 12'd0)) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (!enable || w_abort) begin
                    w_state_nxt = DRAIN;
                end else if (w_credit) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (w_hs) begin
                    w_state_nxt = (w_line_end && w_last_line) ? DRAIN : CALC;
                end
            end
            DRAIN: begin
                if (r_outstanding == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Frame position: latched config, current line/burst address, words left in line, line index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg_stride     <= '0;
            r_cfg_line_words <= '0;
            r_cfg_lines      <= '0;
            r_line_addr      <= '0;
            r_addr           <= '0;
            r_remaining      <= '0;
            r_line_cnt       <= '0;
        end else if (w_start) begin
            r_cfg_stride     <= cfg_stride;
            r_cfg_line_words <= cfg_line_words;
            r_cfg_lines      <= cfg_lines;
            r_line_addr      <= cfg_base_addr;
            r_addr           <= cfg_base_addr;
            r_remaining      <= cfg_line_words;
            r_line_cnt       <= '0;
        end else if (w_hs) begin
            if (w_line_end) begin
                r_line_addr <= r_line_addr + r_cfg_stride;
                r_addr      <= r_line_addr + r_cfg_stride;
                r_remaining <= r_cfg_line_words;
                r_line_cnt  <= r_line_cnt + 11'd1;
            end else begin
                r_addr      <= r_addr + (32'(r_len) << BPB_LOG2);
                r_remaining <= w_rem_after;
            end
        end else if (w_done) begin
            r_line_cnt <= '0;
        end
    end

    // AR channel registers: loaded in CALC, frozen until the handshake retires them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_len     <= '0;
            r_arvalid <= 1'b0;
        end else if (w_issue) begin
            r_araddr  <= r_addr;
            r_arlen   <= 8'(w_len - 13'd1);
            r_len     <= w_len[11:0];
            r_arvalid <= 1'b1;
        end else if (w_hs) begin
            r_arvalid <= 1'b0;
        end
    end

    // In-flight beat count: add a burst on AR handshake, retire one per R beat, never below zero.
    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_hs && w_beat) begin
            w_out_nxt = r_outstanding + FW'(r_len) - FW'(1);
        end else if (w_hs) begin
            w_out_nxt = r_outstanding + FW'(r_len);
        end else if (w_beat && (r_outstanding != '0)) begin
            w_out_nxt = r_outstanding - FW'(1);
        end
    end

    // Outstanding counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
        end
    end

    // Status: busy follows the state, done pulse, sticky error flags where a new event beats a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_resp    <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_busy       <= (w_state_nxt != IDLE);
            r_frame_done <= w_done;
            if (w_beat && (m_axi.rresp != 2'b00)) begin
                r_err_resp <= 1'b1;
            end else if (err_clr) begin
                r_err_resp <= 1'b0;
            end
            if (frame_start && (r_state != IDLE)) begin
                r_err_overrun <= 1'b1;
            end else if (err_clr) begin
                r_err_overrun <= 1'b0;
            end
        end
    end

    assign m_axi.araddr  = r_araddr;
    assign m_axi.arlen   = r_arlen;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.arsize  = 3'(BPB_LOG2);
    assign m_axi.arburst = 2'b01;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;

    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign line_cnt    = r_line_cnt;
    assign err_resp    = r_err_resp;
    assign err_overrun = r_err_overrun;

    // rlast carries no information the beat counter needs.
    assign w_unused = m_axi.rlast;

endmodule

// File: tb/tb_adv7393_frame_fetch.sv
// Bench for adv7393_frame_fetch: frame vectors from a table plus directed credit/overrun/enable/error/reset sequences.
// Latency: checks first-AR (2 cycles) and frame_done (2 cycles after last beat is driven) timing.
// Backpressure: bench models arready stalls and gated R-beat return.
module tb_adv7393_frame_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        enable;
    logic        frame_start;
    logic [31:0] cfg_base_addr;
    logic [31:0] cfg_stride;
    logic [11:0] cfg_line_words;
    logic [10:0] cfg_lines;
    logic [9:0]  fifo_free;
    logic        err_clr;
    logic        busy;
    logic        frame_done;
    logic [10:0] line_cnt;
    logic        err_resp;
    logic        err_overrun;

    adv7393_frame_fetch_if bus();

    adv7393_frame_fetch #(
        .M_AXI_DWIDTH (128),
        .MAX_BURST    (16),
        .FIFO_WORDS   (512)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .enable         (enable),
        .frame_start    (frame_start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_stride     (cfg_stride),
        .cfg_line_words (cfg_line_words),
        .cfg_lines      (cfg_lines),
        .fifo_free      (fifo_free),
        .err_clr        (err_clr),
        .m_axi          (bus),
        .busy           (busy),
        .frame_done     (frame_done),
        .line_cnt       (line_cnt),
        .err_resp       (err_resp),
        .err_overrun    (err_overrun)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- AXI slave / memory model ----------------
    int          cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    bit          ar_rdy_en = 1'b1;
    int          r_allow   = 1000000;
    int          pend      = 0;
    int          beat_no   = 0;
    int          beats_total = 0;
    int          err_beat  = -1;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          last_beat_cyc = 0;
    int          first_vld_cyc = -1;
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;

    initial begin
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rready  = 1'b1;
        bus.rlast   = 1'b0;
        bus.rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend        = 0;
                prev_stall  = 1'b0;
                bus.arready = 1'b0;
                bus.rvalid  = 1'b0;
                bus.rresp   = 2'b00;
            end else begin
                if (frame_done) begin
                    done_cnt++;
                    done_cyc = cyc_n;
                end
                if (prev_stall) begin
                    chk("ar_hold_valid", 32'(bus.arvalid), 32'd1);
                    chk("ar_hold_addr", bus.araddr, prev_addr);
                    chk("ar_hold_len", 32'(bus.arlen), 32'(prev_len));
                end
                if (bus.arvalid && first_vld_cyc < 0) first_vld_cyc = cyc_n;
                // R beats for bursts already accepted
                if (pend > 0 && r_allow > 0) begin
                    beat_no++;
                    beats_total++;
                    pend--;
                    r_allow--;
                    bus.rvalid = 1'b1;
                    bus.rresp  = (beat_no == err_beat) ? 2'b10 : 2'b00;
                    last_beat_cyc = cyc_n;
                end else begin
                    bus.rvalid = 1'b0;
                    bus.rresp  = 2'b00;
                end
                // AR accept for the coming edge
                bus.arready = ar_rdy_en;
                if (bus.arvalid && bus.arready) begin
                    ar_addr_q.push_back(bus.araddr);
                    ar_len_q.push_back(bus.arlen);
                    pend += int'(bus.arlen) + 1;
                end
                prev_stall = bus.arvalid && !bus.arready;
                prev_addr  = bus.araddr;
                prev_len   = bus.arlen;
            end
        end
    end

    // ---------------- helpers ----------------
    int start_cyc = 0;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [31:0] stride,
                               input logic [11:0] words, input logic [10:0] lines);
        ar_addr_q.delete();
        ar_len_q.delete();
        beats_total    = 0;
        beat_no        = 0;
        done_cnt       = 0;
        first_vld_cyc  = -1;
        cfg_base_addr  = base;
        cfg_stride     = stride;
        cfg_line_words = words;
        cfg_lines      = lines;
        frame_start    = 1'b1;
        start_cyc      = cyc_n;
        @(negedge clk);
        frame_start    = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        for (int i = 0; i < limit && done_cnt == 0; i++) @(negedge clk);
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        cyc(3);
    endtask

    task automatic wait_arvalid(input string tag);
        for (int i = 0; i < 10 && !bus.arvalid; i++) @(negedge clk);
        chk({tag, "_arvalid_seen"}, 32'(bus.arvalid), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0]      base;
        logic [31:0]      stride;
        logic [11:0]      words;
        logic [10:0]      lines;
        int               n_ar;
        logic [5:0][31:0] addr;
        logic [5:0][7:0]  len;
        int               beats;
    } vec_t;

    vec_t vecs [7];

    task automatic set_vec(input int i, input logic [31:0] b, input logic [31:0] s,
                           input logic [11:0] w, input logic [10:0] l, input int n, input int bt);
        vecs[i].base   = b;
        vecs[i].stride = s;
        vecs[i].words  = w;
        vecs[i].lines  = l;
        vecs[i].n_ar   = n;
        vecs[i].beats  = bt;
        vecs[i].addr   = '0;
        vecs[i].len    = '0;
    endtask

    task automatic set_ar(input int i, input int j, input logic [31:0] a, input logic [7:0] l);
        vecs[i].addr[j] = a;
        vecs[i].len[j]  = l;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0, 32'h0000_1000, 32'h800, 12'd40, 11'd2, 6, 80);
        set_ar(0, 0, 32'h1000, 8'd15); set_ar(0, 1, 32'h1100, 8'd15); set_ar(0, 2, 32'h1200, 8'd7);
        set_ar(0, 3, 32'h1800, 8'd15); set_ar(0, 4, 32'h1900, 8'd15); set_ar(0, 5, 32'h1A00, 8'd7);
        set_vec(1, 32'h0000_1F80, 32'h100, 12'd16, 11'd1, 2, 16);
        set_ar(1, 0, 32'h1F80, 8'd7);  set_ar(1, 1, 32'h2000, 8'd7);
        set_vec(2, 32'h0000_3000, 32'h100, 12'd8, 11'd0, 0, 0);
        set_vec(3, 32'h0000_3000, 32'h100, 12'd0, 11'd3, 0, 0);
        set_vec(4, 32'hFFFF_FFF0, 32'h10, 12'd1, 11'd2, 2, 2);
        set_ar(4, 0, 32'hFFFF_FFF0, 8'd0); set_ar(4, 1, 32'h0000_0000, 8'd0);
        set_vec(5, 32'h0000_0000, 32'h40, 12'd3, 11'd3, 3, 9);
        set_ar(5, 0, 32'h00, 8'd2); set_ar(5, 1, 32'h40, 8'd2); set_ar(5, 2, 32'h80, 8'd2);
        set_vec(6, 32'h0000_2FF0, 32'h0, 12'd20, 11'd1, 3, 20);
        set_ar(6, 0, 32'h2FF0, 8'd0); set_ar(6, 1, 32'h3000, 8'd15); set_ar(6, 2, 32'h3100, 8'd2);

        rst_n = 1'b0; enable = 1'b1; frame_start = 1'b0; err_clr = 1'b0;
        cfg_base_addr = '0; cfg_stride = '0; cfg_line_words = '0; cfg_lines = '0;
        fifo_free = 10'd512;
        cyc(3);

        // reset state
        chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst_araddr", bus.araddr, 32'd0);
        chk("rst_arlen", 32'(bus.arlen), 32'd0);
        chk("rst_arsize", 32'(bus.arsize), 32'd4);
        chk("rst_arburst", 32'(bus.arburst), 32'd1);
        chk("rst_arcache", 32'(bus.arcache), 32'd3);
        chk("rst_arprot", 32'(bus.arprot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_line_cnt", 32'(line_cnt), 32'd0);
        chk("rst_err_resp", 32'(err_resp), 32'd0);
        chk("rst_err_overrun", 32'(err_overrun), 32'd0);
        #2 rst_n = 1'b1;
        cyc(2);

        // table-driven frames
        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            start_frame(vecs[i].base, vecs[i].stride, vecs[i].words, vecs[i].lines);
            wait_done(400, tag);
            chk({tag, "_ar_count"}, 32'(ar_addr_q.size()), 32'(vecs[i].n_ar));
            for (int j = 0; j < vecs[i].n_ar && j < ar_addr_q.size(); j++) begin
                chk($sformatf("%s_araddr%0d", tag, j), ar_addr_q[j], vecs[i].addr[j]);
                chk($sformatf("%s_arlen%0d", tag, j), 32'(ar_len_q[j]), 32'(vecs[i].len[j]));
            end
            chk({tag, "_beats"}, 32'(beats_total), 32'(vecs[i].beats));
            chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
            chk({tag, "_busy_after"}, 32'(busy), 32'd0);
            chk({tag, "_line_cnt_idle"}, 32'(line_cnt), 32'd0);
            if (vecs[i].n_ar > 0)
                chk({tag, "_first_ar_latency"}, 32'(first_vld_cyc - start_cyc), 32'd2);
            if (vecs[i].beats > 0)
                chk({tag, "_done_latency"}, 32'(done_cyc - last_beat_cyc), 32'd2);
        end
        chk("tbl_err_resp", 32'(err_resp), 32'd0);
        chk("tbl_err_overrun", 32'(err_overrun), 32'd0);

        // credit gating and AR stability under arready stall
        fifo_free = 10'd20; r_allow = 0; ar_rdy_en = 1'b0;
        start_frame(32'h1000, 32'h0, 12'd48, 11'd1);
        cyc(8);
        chk("cr_stall_arvalid", 32'(bus.arvalid), 32'd1);
        chk("cr_stall_araddr", bus.araddr, 32'h1000);
        ar_rdy_en = 1'b1;
        cyc(20);
        chk("cr_one_ar", 32'(ar_addr_q.size()), 32'd1);
        chk("cr_no_arvalid", 32'(bus.arvalid), 32'd0);
        r_allow = 11;
        cyc(20);
        chk("cr_still_one_ar", 32'(ar_addr_q.size()), 32'd1);
        chk("cr_beats11", 32'(beats_total), 32'd11);
        r_allow = 1;
        for (int i = 0; i < 10 && ar_addr_q.size() < 2; i++) @(negedge clk);
        chk("cr_second_ar", 32'(ar_addr_q.size()), 32'd2);
        cyc(10);
        chk("cr_no_third_ar", 32'(ar_addr_q.size()), 32'd2);
        fifo_free = 10'd512; r_allow = 1000000;
        wait_done(400, "cr");
        chk("cr_ar_count", 32'(ar_addr_q.size()), 32'd3);
        if (ar_addr_q.size() == 3) begin
            chk("cr_araddr1", ar_addr_q[1], 32'h1100);
            chk("cr_araddr2", ar_addr_q[2], 32'h1200);
        end
        chk("cr_beats", 32'(beats_total), 32'd48);

        // frame_start while busy, with err_clr in the same cycle: set wins
        start_frame(32'h1000, 32'h800, 12'd40, 11'd2);
        cyc(5);
        frame_start = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; err_clr = 1'b0;
        chk("ov_set", 32'(err_overrun), 32'd1);
        wait_done(400, "ov");
        chk("ov_ar_count", 32'(ar_addr_q.size()), 32'd6);
        chk("ov_beats", 32'(beats_total), 32'd80);
        chk("ov_done_pulses", 32'(done_cnt), 32'd1);
        chk("ov_held", 32'(err_overrun), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ov_cleared", 32'(err_overrun), 32'd0);

        // enable dropped while an AR is waiting for arready
        ar_rdy_en = 1'b0;
        start_frame(32'h1000, 32'h800, 12'd40, 11'd2);
        wait_arvalid("en");
        enable = 1'b0;
        cyc(4);
        chk("en_arvalid_kept", 32'(bus.arvalid), 32'd1);
        ar_rdy_en = 1'b1;
        wait_done(200, "en");
        chk("en_ar_count", 32'(ar_addr_q.size()), 32'd1);
        chk("en_beats", 32'(beats_total), 32'd16);
        chk("en_done_pulses", 32'(done_cnt), 32'd1);
        chk("en_busy", 32'(busy), 32'd0);
        enable = 1'b1;

        // error response on the third beat
        err_beat = 3;
        start_frame(32'h1000, 32'h800, 12'd40, 11'd2);
        wait_done(400, "er");
        chk("er_flag", 32'(err_resp), 32'd1);
        chk("er_done_pulses", 32'(done_cnt), 32'd1);
        chk("er_beats_match_ars", 32'(beats_total), 32'(16 * ar_addr_q.size() - ((ar_addr_q.size() >= 3) ? 8 : 0) - ((ar_addr_q.size() >= 6) ? 8 : 0)));
`ifdef ADV7393_FETCH_ERR_ABORT_EN
        chk("er_aborted", 32'(ar_addr_q.size() < 6), 32'd1);
`else
        chk("er_full_frame", 32'(ar_addr_q.size()), 32'd6);
`endif
        err_beat = -1;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("er_cleared", 32'(err_resp), 32'd0);

        // reset while an AR is pending drops arvalid at once
        ar_rdy_en = 1'b0;
        start_frame(32'h1000, 32'h800, 12'd40, 11'd2);
        wait_arvalid("rs");
        #2 rst_n = 1'b0;
        #1;
        chk("rs_arvalid_drop", 32'(bus.arvalid), 32'd0);
        chk("rs_busy_drop", 32'(busy), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ar_rdy_en = 1'b1;
        cyc(3);
        chk("rs_idle_busy", 32'(busy), 32'd0);
        chk("rs_idle_line_cnt", 32'(line_cnt), 32'd0);
        chk("rs_idle_arvalid", 32'(bus.arvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
